stall_mem: RTL and testbench
============================

STALL_MEM -- requirements
Module: stall_mem

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 16, byte-address width in bits.
REQ-003 Parameter DEPTH_LOG2, default 10, log2 of the number of words stored.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to done; legal range 1..15.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 addr  input  ADDR_W  byte address of the access.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 rd  input  1  read request.
REQ-010 wr  input  1  write request.
REQ-011 data_out  output  DATA_W  read data; valid only while done=1 for a read.
REQ-012 stall  output  1  access in flight; new requests are ignored.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle error pulse.

Function
REQ-015 The word index SHALL be addr[DEPTH_LOG2:1]; address bits above DEPTH_LOG2 SHALL be ignored, so addresses wrap modulo the depth.
REQ-016 A request SHALL be accepted at the clock edge ending cycle 0 when stall=0, done-or-idle, and exactly one of rd or wr is 1.
REQ-017 The FSM SHALL have three states:
  - IDLE -> WAIT on accept when LATENCY>1; IDLE -> RESP on accept when LATENCY=1.
  - WAIT -> RESP when the down-counter reaches 0.
  - RESP -> WAIT or RESP on a new accept; RESP -> IDLE otherwise.
REQ-018 On accept, addr, data_in and the op SHALL be captured; the counter SHALL load LATENCY-2.
REQ-019 stall SHALL be 1 in cycles 1..LATENCY-1 after accept and 0 in every other cycle.
REQ-020 done SHALL be 1 in exactly cycle LATENCY after accept.
REQ-021 A write SHALL commit to the array at the edge ending cycle LATENCY-1, so the commit coincides with done rising.
REQ-022 Read data SHALL be sampled at that same edge and held on data_out for the done cycle.
REQ-023 data_out SHALL be 0 in cycles without a read done.
REQ-024 A new request MAY be accepted in the RESP cycle, giving back-to-back throughput of one access per LATENCY cycles.
REQ-025 A read following a write to the same word SHALL return the new data.
REQ-026 Misaligned access (addr[0]=1) SHALL be accepted and timed normally.
  - err=1 together with done.
  - A write SHALL not commit.
  - data_out SHALL be 0.
REQ-027 rd=wr=1 while stall=0 SHALL not be accepted; err=1 in the following cycle, done=0, and state is unchanged.
REQ-028 rd or wr asserted while stall=1 SHALL be ignored without error.
REQ-029 No output SHALL be X after reset, for any input sequence.

Reset
REQ-030 While rst=1 at an edge:
  - state -> IDLE and counter -> 0.
  - stall, done, err and data_out -> 0 in the next cycle.
REQ-031 Reset during WAIT SHALL abandon the access; its pending write SHALL not commit.
REQ-032 Reset SHALL not clear array contents.
REQ-033 A request presented with rst=1 SHALL not be accepted.

Structure
REQ-034 A shared package stall_mem_pkg SHALL hold:
  - the state enum (IDLE, WAIT, RESP);
  - the parameter defaults;
  - the counter width constant of 4 bits.
REQ-035 Storage SHALL be one sub-module, stall_mem_array: single port, synchronous write, registered read, 2**DEPTH_LOG2 x DATA_W.
REQ-036 The FSM, counter and capture registers SHALL live in stall_mem.

Verification
REQ-037 LATENCY=2:
  - Cycle 0: wr, addr=0x0010, data_in=0xBEEF.
  - Cycle 1: stall=1. Cycle 2: done=1, err=0.
  - Then rd of 0x0010 -> data_out=0xBEEF with done, two cycles later.
REQ-038 LATENCY=1, back-to-back: rd of 0x0002, 0x0004 and 0x0006 on consecutive cycles -> stall never 1, and done=1 in cycles 1, 2 and 3 with the matching data.
REQ-039 Misaligned and conflicting requests:
  - wr addr=0x0011, data_in=0x1234 -> done and err pulse together.
  - A read of 0x0010 still returns the prior value.
  - rd=wr=1 -> err one cycle later, done never.
REQ-040 Wrap-around: DEPTH_LOG2=10, wr addr=0x0802, data_in=0x5A5A, then rd addr=0x0002 -> 0x5A5A.
REQ-041 Reset mid-operation:
  - LATENCY=4, wr 0x0020=0xFFFF accepted, rst=1 in cycle 2.
  - Outputs 0 in cycle 3.
  - A later rd of 0x0020 returns the value held before that write.
REQ-042 Requests while stall=1 with LATENCY=3: rd in cycles 1 and 2 -> exactly one done, in cycle 3.

Source files
------------

// File: rtl/stall_mem_pkg.sv
// Shared types and defaults for the stall_mem fixed-latency memory.
package stall_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DATA_W_DEF     = 16;
    localparam int ADDR_W_DEF     = 16;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int LATENCY_DEF    = 2;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/stall_mem_array.sv
// Single-port word storage: synchronous write, registered read, no reset on contents.
module stall_mem_array
    import stall_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stall_mem.sv
// Fixed-latency memory front end: accepts one access at a time, stalls for
// LATENCY-1 cycles, then pulses done (and err for misaligned/conflicting requests).
module stall_mem
    import stall_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    mis_q, mis_d;
    logic                    op_wr_q, op_wr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    rd_ok_q, rd_ok_d;

    logic [DEPTH_LOG2-1:0]   idx_in;
    logic                    mis_in;
    logic                    unused_addr_hi;
    logic                    ready, accept, conflict, access;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    acc_mis, acc_wr;
    logic [DATA_W-1:0]       acc_data;
    logic                    mem_we, mem_re;
    logic [DATA_W-1:0]       mem_rdata;

    // Upper address bits are deliberately dropped so addresses wrap over the depth.
    assign idx_in         = addr[DEPTH_LOG2:1];
    assign mis_in         = addr[0];
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+1];

    // With LATENCY=1 the array is accessed on the accept edge itself, so it
    // must see the live request rather than the captured copy.
    always_comb begin
        ready    = (state_q == IDLE) || (state_q == RESP);
        accept   = !rst && ready && (rd ^ wr);
        conflict = !rst && ready && rd && wr;
        if (LATENCY == 1) begin
            access   = accept;
            acc_idx  = idx_in;
            acc_mis  = mis_in;
            acc_wr   = wr;
            acc_data = data_in;
        end else begin
            access   = !rst && (state_q == WAIT) && (cnt_q == '0);
            acc_idx  = idx_q;
            acc_mis  = mis_q;
            acc_wr   = op_wr_q;
            acc_data = wdata_q;
        end
        mem_we  = access && acc_wr && !acc_mis;
        mem_re  = access && !acc_wr && !acc_mis;
        done_d  = access;
        err_d   = (access && acc_mis) || conflict;
        rd_ok_d = mem_re;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mis_d   = mis_q;
        op_wr_d = op_wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                    cnt_d   = CNT_LOAD;
                    idx_d   = idx_in;
                    mis_d   = mis_in;
                    op_wr_d = wr;
                    wdata_d = data_in;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            op_wr_q <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            op_wr_q <= op_wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    stall_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (acc_idx),
        .wdata (acc_data),
        .rdata (mem_rdata)
    );

    assign stall    = (state_q == WAIT);
    assign done     = done_q;
    assign err      = err_q;
    assign data_out = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_stall_mem.sv
// Bench for stall_mem: four instances (LATENCY 2, 1, 4, 3) checked every cycle
// against a transaction-level model, plus hand-computed spot checks.
module tb_stall_mem;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]       rst_v, rd_v, wr_v, stall_v, done_v, err_v;
    logic [N-1:0][15:0] addr_v, din_v, dout_v;

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        stall_mem #(
            .DATA_W     (16),
            .ADDR_W     (16),
            .DEPTH_LOG2 (10),
            .LATENCY    ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3)
        ) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .addr     (addr_v[g]),
            .data_in  (din_v[g]),
            .rd       (rd_v[g]),
            .wr       (wr_v[g]),
            .data_out (dout_v[g]),
            .stall    (stall_v[g]),
            .done     (done_v[g]),
            .err      (err_v[g])
        );
    end

    // Model: an access is tracked by its age in cycles since acceptance.
    bit          m_ready  [N];
    bit          m_active [N];
    int          m_age    [N];
    bit          m_op_wr  [N];
    bit          m_op_mis [N];
    int          m_op_idx [N];
    logic [15:0] m_op_data[N];
    logic [15:0] m_mem    [N][1024];
    bit          m_known  [N][1024];
    logic        exp_stall[N];
    logic        exp_done [N];
    logic        exp_err  [N];
    logic [15:0] exp_data [N];
    bit          exp_data_known[N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int lat;
            bit stalled;
            lat = lat_of(i);
            if (rst_v[i]) begin
                m_ready[i]        = 1'b1;
                m_active[i]       = 1'b0;
                exp_stall[i]      = 1'b0;
                exp_done[i]       = 1'b0;
                exp_err[i]        = 1'b0;
                exp_data[i]       = 16'h0;
                exp_data_known[i] = 1'b1;
            end else begin
                stalled           = m_active[i] && (m_age[i] < lat);
                exp_done[i]       = 1'b0;
                exp_err[i]        = 1'b0;
                exp_data[i]       = 16'h0;
                exp_data_known[i] = 1'b1;
                if (m_active[i]) begin
                    m_age[i] = m_age[i] + 1;
                    if (m_age[i] > lat) m_active[i] = 1'b0;
                end
                if (!stalled && (rd_v[i] != wr_v[i])) begin
                    m_active[i]  = 1'b1;
                    m_age[i]     = 1;
                    m_op_wr[i]   = wr_v[i];
                    m_op_mis[i]  = (int'(addr_v[i]) % 2) == 1;
                    m_op_idx[i]  = (int'(addr_v[i]) / 2) % 1024;
                    m_op_data[i] = din_v[i];
                end else if (!stalled && rd_v[i] && wr_v[i]) begin
                    exp_err[i] = 1'b1;
                end
                if (m_active[i] && m_age[i] == lat) begin
                    exp_done[i] = 1'b1;
                    if (m_op_mis[i]) begin
                        exp_err[i] = 1'b1;
                    end else if (m_op_wr[i]) begin
                        m_mem[i][m_op_idx[i]]   = m_op_data[i];
                        m_known[i][m_op_idx[i]] = 1'b1;
                    end else begin
                        exp_data[i]       = m_mem[i][m_op_idx[i]];
                        exp_data_known[i] = m_known[i][m_op_idx[i]];
                    end
                end
                exp_stall[i] = m_active[i] && (m_age[i] < lat);
            end
        end
    end

    task automatic compareField(input string name, input int inst,
                                input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s dut%0d t=%0t: got %h, expected %h", name, inst, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (m_ready[i]) begin
                compareField("stall", i, {15'b0, stall_v[i]}, {15'b0, exp_stall[i]});
                compareField("done",  i, {15'b0, done_v[i]},  {15'b0, exp_done[i]});
                compareField("err",   i, {15'b0, err_v[i]},   {15'b0, exp_err[i]});
                if (exp_data_known[i]) compareField("data_out", i, dout_v[i], exp_data[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int inst, input logic r, input logic w,
                                 input logic [15:0] a, input logic [15:0] d);
        rd_v[inst]   = r;
        wr_v[inst]   = w;
        addr_v[inst] = a;
        din_v[inst]  = d;
    endtask

    task automatic idle(input int inst);
        applyStimulus(inst, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Literal expectations pin both the DUT and the model.
    task automatic checkOutput(input string name, input int inst, input logic s,
                               input logic dn, input logic e, input logic [15:0] dat);
        compareField({name, ".stall"}, inst, {15'b0, stall_v[inst]}, {15'b0, s});
        compareField({name, ".done"},  inst, {15'b0, done_v[inst]},  {15'b0, dn});
        compareField({name, ".err"},   inst, {15'b0, err_v[inst]},   {15'b0, e});
        compareField({name, ".data"},  inst, dout_v[inst], dat);
        compareField({name, ".model_done"}, inst, {15'b0, exp_done[inst]}, {15'b0, dn});
        compareField({name, ".model_data"}, inst, exp_data[inst], dat);
    endtask

    initial begin
        rst_v  = '1;
        rd_v   = '0;
        wr_v   = '0;
        addr_v = '0;
        din_v  = '0;
        tick();
        tick();
        rst_v = '0;
        for (int i = 0; i < N; i++) checkOutput("reset", i, 1'b0, 1'b0, 1'b0, 16'h0);

        // LATENCY=2: write, read back, misaligned, conflict, wrap-around
        applyStimulus(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        tick(); idle(0); checkOutput("a_wr_c1", 0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();          checkOutput("a_wr_c2", 0, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        tick(); idle(0); checkOutput("a_rd_c1", 0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();          checkOutput("a_rd_c2", 0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        applyStimulus(0, 1'b0, 1'b1, 16'h0011, 16'h1234);
        tick(); idle(0); tick(); checkOutput("a_mis_wr", 0, 1'b0, 1'b1, 1'b1, 16'h0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        tick(); idle(0); tick(); checkOutput("a_after_mis", 0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        applyStimulus(0, 1'b1, 1'b0, 16'h0011, 16'h0);
        tick(); idle(0); tick(); checkOutput("a_mis_rd", 0, 1'b0, 1'b1, 1'b1, 16'h0);
        tick();
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h9999);
        tick(); idle(0); checkOutput("a_conf_c1", 0, 1'b0, 1'b0, 1'b1, 16'h0);
        tick();          checkOutput("a_conf_c2", 0, 1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        tick(); idle(0); tick(); checkOutput("a_after_conf", 0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        applyStimulus(0, 1'b0, 1'b1, 16'h0802, 16'h5A5A);
        tick(); idle(0); tick();
        applyStimulus(0, 1'b1, 1'b0, 16'h0002, 16'h0);
        tick(); idle(0); tick(); checkOutput("a_wrap", 0, 1'b0, 1'b1, 1'b0, 16'h5A5A);
        tick();

        // LATENCY=1: back-to-back writes then reads, plus read right after write
        applyStimulus(1, 1'b0, 1'b1, 16'h0002, 16'h1111);
        tick(); checkOutput("b_w2", 1, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0004, 16'h2222);
        tick(); checkOutput("b_w4", 1, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0006, 16'h3333);
        tick(); checkOutput("b_w6", 1, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0002, 16'h0);
        tick(); checkOutput("b_r2", 1, 1'b0, 1'b1, 1'b0, 16'h1111);
        applyStimulus(1, 1'b1, 1'b0, 16'h0004, 16'h0);
        tick(); checkOutput("b_r4", 1, 1'b0, 1'b1, 1'b0, 16'h2222);
        applyStimulus(1, 1'b1, 1'b0, 16'h0006, 16'h0);
        tick(); checkOutput("b_r6", 1, 1'b0, 1'b1, 1'b0, 16'h3333);
        applyStimulus(1, 1'b0, 1'b1, 16'h0008, 16'h4444);
        tick();
        applyStimulus(1, 1'b1, 1'b0, 16'h0008, 16'h0);
        tick(); checkOutput("b_raw", 1, 1'b0, 1'b1, 1'b0, 16'h4444);
        idle(1);
        tick(); checkOutput("b_idle", 1, 1'b0, 1'b0, 1'b0, 16'h0);

        // LATENCY=4: reset abandons a pending write; request under reset ignored
        applyStimulus(2, 1'b0, 1'b1, 16'h0020, 16'h00AA);
        tick(); idle(2); tick(); tick(); tick();
        checkOutput("c_pre", 2, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(2, 1'b0, 1'b1, 16'h0020, 16'hFFFF);
        tick(); idle(2);
        tick(); rst_v[2] = 1'b1;
        tick(); rst_v[2] = 1'b0;
        checkOutput("c_rst", 2, 1'b0, 1'b0, 1'b0, 16'h0);
        rst_v[2] = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        tick(); rst_v[2] = 1'b0; idle(2);
        checkOutput("c_rst_req", 2, 1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(2, 1'b1, 1'b0, 16'h0020, 16'h0);
        tick(); idle(2); checkOutput("c_rd_c1", 2, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(); tick(); tick();
        checkOutput("c_rd_c4", 2, 1'b0, 1'b1, 1'b0, 16'h00AA);

        // LATENCY=3: requests while stalled are ignored
        applyStimulus(3, 1'b0, 1'b1, 16'h0030, 16'h7777);
        tick(); idle(3); tick(); tick();
        checkOutput("d_pre", 3, 1'b0, 1'b1, 1'b0, 16'h0);
        applyStimulus(3, 1'b1, 1'b0, 16'h0030, 16'h0);
        tick(); applyStimulus(3, 1'b1, 1'b0, 16'h0040, 16'h0);
        checkOutput("d_c1", 3, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(); applyStimulus(3, 1'b0, 1'b1, 16'h0030, 16'hDEAD);
        checkOutput("d_c2", 3, 1'b1, 1'b0, 1'b0, 16'h0);
        tick(); idle(3);
        checkOutput("d_c3", 3, 1'b0, 1'b1, 1'b0, 16'h7777);
        tick(); checkOutput("d_c4", 3, 1'b0, 1'b0, 1'b0, 16'h0);
        applyStimulus(3, 1'b1, 1'b0, 16'h0030, 16'h0);
        tick(); idle(3); tick(); tick();
        checkOutput("d_reread", 3, 1'b0, 1'b1, 1'b0, 16'h7777);

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
